approx_mult_reconstruct: RTL and testbench

- Sequential shift-add multiply-accumulate that reconstructs a 16-bit dividend from divider outputs: x = q*y + r.
- It is the inverse path of the 16/8 array divider. It runs in the same datapath as a checker and reconstructor for divider quotient/remainder pairs.
- Its partial-product adder has an optional approximate low-column region. This mirrors the divider's approximate low-column subtractor cells, so error behaviour can be studied in both directions.

---
 rtl/approx_mult_reconstruct.sv | 128 ++++++++++++
 tb/tb_approx_mult_reconstruct.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_reconstruct.sv
// Sequential shift-add reconstructor x = q*y + r, the inverse path of the 16/8 array divider.
// The low APPROX_BITS columns of the partial-product adder use carry-dropping approximate cells.
module approx_mult_reconstruct #(
    parameter int APPROX_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  q,
    input  logic [7:0]  y,
    input  logic [7:0]  r,
    output logic        busy,
    output logic        done,
    output logic [15:0] x
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] p;
    logic [15:0] p_nxt;
    logic [7:0]  yr;
    logic [7:0]  yr_nxt;
    logic [7:0]  rr;
    logic [7:0]  rr_nxt;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nxt;
    logic [15:0] x_nxt;
    logic        busy_nxt;
    logic        done_nxt;

    logic [7:0]  add_sum;
    logic        add_cout;
    logic [15:0] step_p;

    // Approximate cells ignore their carry-in and emit a&b as carry-out.
    always_comb begin
        logic carry;
        carry   = 1'b0;
        add_sum = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < APPROX_BITS) begin
                add_sum[i] = p[8+i] ^ yr[i];
                carry      = p[8+i] & yr[i];
            end else begin
                add_sum[i] = p[8+i] ^ yr[i] ^ carry;
                carry      = (p[8+i] & yr[i]) | (carry & (p[8+i] ^ yr[i]));
            end
        end
        add_cout = carry;
    end

    always_comb begin
        if (p[0]) begin
            step_p = {add_cout, add_sum, p[7:1]};
        end else begin
            step_p = {1'b0, p[15:8], p[7:1]};
        end
    end

    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        yr_nxt    = yr;
        rr_nxt    = rr;
        cnt_nxt   = cnt;
        x_nxt     = x;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    yr_nxt    = y;
                    rr_nxt    = r;
                    p_nxt     = {8'h00, q};
                    cnt_nxt   = 3'd0;
                    busy_nxt  = 1'b1;
                    state_nxt = MUL;
                end
            end
            MUL: begin
                p_nxt   = step_p;
                cnt_nxt = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                x_nxt     = p + {8'h00, rr};
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            p     <= '0;
            yr    <= '0;
            rr    <= '0;
            cnt   <= '0;
            x     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            p     <= p_nxt;
            yr    <= yr_nxt;
            rr    <= rr_nxt;
            cnt   <= cnt_nxt;
            x     <= x_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_approx_mult_reconstruct.sv
// Directed self-checking bench for approx_mult_reconstruct; an exact and an APPROX_BITS=2 build share inputs.
module tb_approx_mult_reconstruct;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  q;
    logic [7:0]  y;
    logic [7:0]  r;
    logic        busy0;
    logic        done0;
    logic [15:0] x0;
    logic        busy2;
    logic        done2;
    logic [15:0] x2;

    int n_compared;
    int n_mismatched;

    approx_mult_reconstruct #(.APPROX_BITS(0)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .q    (q),
        .y    (y),
        .r    (r),
        .busy (busy0),
        .done (done0),
        .x    (x0)
    );

    approx_mult_reconstruct #(.APPROX_BITS(2)) dut2 (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .q    (q),
        .y    (y),
        .r    (r),
        .busy (busy2),
        .done (done2),
        .x    (x2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; the following posedge accepts the operands.
    task automatic issue_op(input logic [7:0] qv, input logic [7:0] yv, input logic [7:0] rv);
        q     = qv;
        y     = yv;
        r     = rv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered one negedge after the accept edge; returns at the negedge where done is seen.
    task automatic wait_done(input string name, input bit scramble);
        int lat;
        bit bad_busy;
        lat      = 1;
        bad_busy = 1'b0;
        while (done0 !== 1'b1 && lat < 20) begin
            if (busy0 !== 1'b1) bad_busy = 1'b1;
            if (scramble) begin
                q = 8'($urandom);
                y = 8'($urandom);
                r = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        n_compared++;
        if (lat !== 10) begin
            n_mismatched++;
            $display("[TB] FAIL %s_latency: got %0d clocks, expected 10", name, lat);
        end
        n_compared++;
        if (bad_busy || busy0 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL %s_busy: busy low during op=%0d, busy with done=%b, expected 0/0", name, bad_busy, busy0);
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        q     = 8'h00;
        y     = 8'h00;
        r     = 8'h00;
        repeat (3) @(negedge clk);
        n_compared++;
        if ({busy0, done0, x0} !== 18'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b x=%h, expected 0 0 0000", busy0, done0, x0);
        end
        rst = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({busy0, done0} !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL idle_no_start: got busy=%b done=%b, expected 0 0", busy0, done0);
        end
    endtask

    task automatic test_basic();
        issue_op(8'h12, 8'h34, 8'h05);
        wait_done("basic", 1'b0);
        n_compared++;
        if (x0 !== 16'h03AD) begin
            n_mismatched++;
            $display("[TB] FAIL basic_x: got %h, expected 03ad", x0);
        end
        @(negedge clk);
        n_compared++;
        if (done0 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL done_one_cycle: got %b, expected 0", done0);
        end
        repeat (3) @(negedge clk);
        n_compared++;
        if (x0 !== 16'h03AD) begin
            n_mismatched++;
            $display("[TB] FAIL x_hold: got %h, expected 03ad", x0);
        end
    endtask

    task automatic test_back_to_back();
        issue_op(8'hFF, 8'hFF, 8'hFF);
        wait_done("max", 1'b0);
        n_compared++;
        if (x0 !== 16'hFF00) begin
            n_mismatched++;
            $display("[TB] FAIL max_x: got %h, expected ff00", x0);
        end
        issue_op(8'hAB, 8'h00, 8'h07);
        wait_done("b2b", 1'b0);
        n_compared++;
        if (x0 !== 16'h0007) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_x: got %h, expected 0007", x0);
        end
        @(negedge clk);
    endtask

    task automatic test_approx();
        issue_op(8'h03, 8'h03, 8'h00);
        wait_done("approx", 1'b0);
        n_compared++;
        if (x2 !== 16'h0005) begin
            n_mismatched++;
            $display("[TB] FAIL approx2_x: got %h, expected 0005", x2);
        end
        n_compared++;
        if (x0 !== 16'h0009) begin
            n_mismatched++;
            $display("[TB] FAIL exact_x: got %h, expected 0009", x0);
        end
        n_compared++;
        if (done2 !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL approx2_done: got %b, expected 1", done2);
        end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int lat;
        int n;
        issue_op(8'h21, 8'h0B, 8'h03);
        lat = 1;
        while (done0 !== 1'b1 && lat < 20) begin
            start = 1'b1;
            q     = q + 8'h11;
            y     = y + 8'h05;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        n_compared++;
        if (lat !== 10 || x0 !== 16'h016E) begin
            n_mismatched++;
            $display("[TB] FAIL busy_start_x: got lat=%0d x=%h, expected lat=10 x=016e", lat, x0);
        end
        count_dones(14, n);
        n_compared++;
        if (n !== 0) begin
            n_mismatched++;
            $display("[TB] FAIL busy_start_extra_done: got %0d, expected 0", n);
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        issue_op(8'h55, 8'h66, 8'h77);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_compared++;
        if ({busy0, done0, x0} !== 18'h0 || x2 !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset: got busy=%b done=%b x=%h x2=%h, expected 0 0 0000 0000", busy0, done0, x0, x2);
        end
        rst = 1'b0;
        count_dones(14, n);
        n_compared++;
        if (n !== 0 || busy0 !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset_no_done: got dones=%0d busy=%b, expected 0 0", n, busy0);
        end
        issue_op(8'h10, 8'h10, 8'h01);
        wait_done("after_reset", 1'b0);
        n_compared++;
        if (x0 !== 16'h0101) begin
            n_mismatched++;
            $display("[TB] FAIL after_reset_x: got %h, expected 0101", x0);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [7:0]  qv;
        logic [7:0]  yv;
        logic [7:0]  rv;
        logic [15:0] exp_x;
        int          bad;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            qv    = 8'($urandom);
            yv    = 8'($urandom);
            rv    = 8'($urandom);
            exp_x = 16'(qv) * 16'(yv) + 16'(rv);
            issue_op(qv, yv, rv);
            wait_done("sweep", 1'b1);
            n_compared++;
            if (x0 !== exp_x) begin
                n_mismatched++;
                bad++;
                if (bad <= 5)
                    $display("[TB] FAIL sweep_x q=%h y=%h r=%h: got %h, expected %h", qv, yv, rv, x0, exp_x);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_approx();
        test_start_while_busy();
        test_reset_mid_op();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
